// File: rtl/hack_alu_pkg.sv
// Shared Hack ALU definitions: control words and multiplier sequencer states.
// Used by the ALU, the multiply sequencer and their integration wrapper.
package hack_alu_pkg;

  localparam logic [5:0] CTL_X_PLUS_Y = 6'b000010;
  localparam logic [5:0] CTL_X_PLUS_0 = 6'b001010;
  localparam logic [5:0] CTL_ZERO     = 6'b101010;
  localparam logic [5:0] CTL_IDLE     = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: zx/nx/zy/ny preset, f selects add or and,
// no negates the result; zr/ng flag the output.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [5:0]  ctl,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] xa, ya, o;

  always_comb begin
    xa  = ctl[5] ? 16'h0000 : x;
    xa  = ctl[4] ? ~xa : xa;
    ya  = ctl[3] ? 16'h0000 : y;
    ya  = ctl[2] ? ~ya : ya;
    o   = ctl[1] ? (xa + ya) : (xa & ya);
    out = ctl[0] ? ~o : o;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: rtl/hack_mul_unit.sv
// Integration wrapper: the multiply sequencer paired with one Hack ALU.
// The ALU ports are internal here; only the handshakes are exposed.
module hack_mul_unit #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        out_zr,
  output logic        out_ng
);

  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng;

  alu_mul_sequencer #(
    .WIDTH      (16),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_seq (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_zr    (out_zr),
    .out_ng    (out_ng),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_ctl   (alu_ctl),
    .alu_out   (alu_out),
    .alu_zr    (alu_zr),
    .alu_ng    (alu_ng)
  );

  hack_alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .ctl (alu_ctl),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16-bit multiplier that borrows the external Hack ALU,
// alternating ADD (acc += bit ? mcand : 0) and DBL (mcand += mcand).
module alu_mul_sequencer
  import hack_alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_zr,
  output logic             out_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  localparam int IW = $clog2(WIDTH);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [IW-1:0]    bit_idx_q;
  logic             zr_q, ng_q;
  logic             accept, last_bit, rest_zero;

  assign accept    = in_valid & in_ready;
  assign last_bit  = (bit_idx_q == IW'(WIDTH - 1));
  assign rest_zero = (mplier_q[WIDTH-1:1] == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ADD;
      ADD: begin
        if (last_bit || (EARLY_EXIT && rest_zero))
          state_d = DONE;
        else
          state_d = DBL;
      end
      DBL:  state_d = ADD;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_p     = '0;
    out_zr    = 1'b0;
    out_ng    = 1'b0;
    alu_x     = '0;
    alu_y     = '0;
    alu_ctl   = CTL_IDLE;
    unique case (state_q)
      ADD: begin
        alu_x   = acc_q;
        alu_y   = mcand_q;
        // A clear multiplier bit zeroes y so the add contributes nothing
        alu_ctl = mplier_q[0] ? CTL_X_PLUS_Y : CTL_X_PLUS_0;
      end
      DBL: begin
        alu_x   = mcand_q;
        alu_y   = mcand_q;
        alu_ctl = CTL_X_PLUS_Y;
      end
      DONE: begin
        out_p  = acc_q;
        out_zr = zr_q;
        out_ng = ng_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      bit_idx_q <= '0;
      zr_q      <= 1'b0;
      ng_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q     <= '0;
            mcand_q   <= in_a;
            mplier_q  <= in_b;
            bit_idx_q <= '0;
          end
        end
        ADD: begin
          acc_q    <= alu_out;
          zr_q     <= alu_zr;
          ng_q     <= alu_ng;
          mplier_q <= mplier_q >> 1;
        end
        DBL: begin
          mcand_q   <= alu_out;
          bit_idx_q <= bit_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
